// File: rtl/fifo_wr_rd_slave_pkg.sv
// Shared constants, data word type and sizing helper for the wr_rd FIFO responder.
package fifo_pkg;

   localparam int   WIDTH_DEF = 8;
   localparam logic OP_WR     = 1'b1;
   localparam logic OP_RD     = 1'b0;

   typedef logic [WIDTH_DEF-1:0] word_t;

   // Occupancy needs one extra bit so that a completely full FIFO (count == DEPTH) is representable.
   function automatic int cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/fifo_wr_rd_slave_if.sv
// Single-control wr_rd port: one op strobe selects write or read, status flows back.
interface fifo_wr_rd_slave_if
   import fifo_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int DEPTH = 16
) ();

   localparam int CW = cnt_w(DEPTH);

   logic             op_en;
   logic             wr_rd;
   logic             err_clr;
   logic [WIDTH-1:0] D_in;
   logic [WIDTH-1:0] D_out;
   logic             full;
   logic             empty;
   logic             almost_full;
   logic [CW-1:0]    count;
   logic             overflow;
   logic             underflow;

   modport master (
      output op_en, wr_rd, D_in, err_clr,
      input  D_out, full, empty, almost_full, count, overflow, underflow
   );

   modport slave (
      input  op_en, wr_rd, D_in, err_clr,
      output D_out, full, empty, almost_full, count, overflow, underflow
   );

endinterface

// File: rtl/fifo_wr_rd_slave_mem.sv
// DEPTH x WIDTH storage: synchronous write port, registered read port gated by re.
module fifo_mem #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     re,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [WIDTH-1:0]         rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Array is intentionally left out of reset; only the output register is cleared.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)    rdata <= '0;
      else if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/fifo_wr_rd_slave.sv
// Synchronous FIFO responder: pointer/count/flag control around fifo_mem, with sticky error flags.
module fifo_wr_rd_slave
   import fifo_pkg::*;
#(
   parameter int WIDTH    = WIDTH_DEF,
   parameter int DEPTH    = 16,
   parameter int AFULL_TH = 12
) (
   input logic              clk,
   input logic              rst,
   fifo_wr_rd_slave_if.slave bus
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = cnt_w(DEPTH);

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count_q;
   logic          overflow_q;
   logic          underflow_q;

   logic is_wr, is_rd, full_c, empty_c, do_wr, do_rd;

   assign is_wr   = bus.op_en && (bus.wr_rd == OP_WR);
   assign is_rd   = bus.op_en && (bus.wr_rd == OP_RD);
   assign full_c  = (count_q == CW'(DEPTH));
   assign empty_c = (count_q == '0);
   assign do_wr   = is_wr && !full_c;
   assign do_rd   = is_rd && !empty_c;

   // Pointers wrap naturally because DEPTH is a power of two; occupancy is tracked by count_q.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + AW'(1);
         if (do_rd) rd_ptr <= rd_ptr + AW'(1);
         if (do_wr)      count_q <= count_q + CW'(1);
         else if (do_rd) count_q <= count_q - CW'(1);
      end
   end

   // A new error in the same cycle as err_clr keeps the flag set.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (is_wr && full_c)  overflow_q <= 1'b1;
         else if (bus.err_clr) overflow_q <= 1'b0;
         if (is_rd && empty_c) underflow_q <= 1'b1;
         else if (bus.err_clr) underflow_q <= 1'b0;
      end
   end

   fifo_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk   (clk),
      .rst   (rst),
      .we    (do_wr),
      .waddr (wr_ptr),
      .wdata (bus.D_in),
      .re    (do_rd),
      .raddr (rd_ptr),
      .rdata (bus.D_out)
   );

   assign bus.count       = count_q;
   assign bus.full        = full_c;
   assign bus.empty       = empty_c;
   assign bus.almost_full = (count_q >= CW'(AFULL_TH));
   assign bus.overflow    = overflow_q;
   assign bus.underflow   = underflow_q;

endmodule

// File: tb/tb_fifo_wr_rd_slave.sv
// Directed-vector bench for fifo_wr_rd_slave with hand-computed expectations.
module tb_fifo_wr_rd_slave;
   import fifo_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   vectors = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   fifo_wr_rd_slave_if #(.WIDTH(8), .DEPTH(16)) bus ();

   fifo_wr_rd_slave #(
      .WIDTH    (8),
      .DEPTH    (16),
      .AFULL_TH (12)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Apply one op for exactly one edge; outputs are stable 1 time unit after that edge.
   task automatic op(input logic w, input word_t d);
      bus.op_en = 1'b1;
      bus.wr_rd = w;
      bus.D_in  = d;
      @(posedge clk);
      #1;
      bus.op_en = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      bus.op_en = 1'b0; bus.wr_rd = 1'b0; bus.D_in = '0; bus.err_clr = 1'b0;
      rst = 1'b0;
      idle(2);
      rst = 1'b1;
      idle(5);
      vectors++;
      if ({bus.empty, bus.full, bus.almost_full, bus.overflow, bus.underflow} !== 5'b10000) begin
         miscompares++;
         $display("FAIL reset_flags: got %b expected 10000", {bus.empty, bus.full, bus.almost_full, bus.overflow, bus.underflow});
      end
      vectors++;
      if (bus.count !== 5'd0) begin
         miscompares++; $display("FAIL reset_count: got %0d expected 0", bus.count);
      end
      vectors++;
      if (bus.D_out !== 8'h00) begin
         miscompares++; $display("FAIL reset_dout: got %h expected 00", bus.D_out);
      end
   endtask

   task automatic test_basic;
      word_t vals [3] = '{8'h11, 8'h22, 8'h33};
      for (int i = 0; i < 3; i++) op(OP_WR, vals[i]);
      // op_en low must ignore wr_rd/D_in activity
      bus.wr_rd = OP_WR; bus.D_in = 8'hEE;
      idle(3);
      vectors++;
      if (bus.count !== 5'd3) begin
         miscompares++; $display("FAIL basic_count_after_wr: got %0d expected 3", bus.count);
      end
      for (int i = 0; i < 3; i++) begin
         op(OP_RD, 8'h00);
         vectors++;
         if (bus.D_out !== vals[i] || bus.count !== 5'(2 - i)) begin
            miscompares++;
            $display("FAIL basic_read%0d: got data %h count %0d expected data %h count %0d", i, bus.D_out, bus.count, vals[i], 2 - i);
         end
      end
      vectors++;
      if (bus.empty !== 1'b1) begin
         miscompares++; $display("FAIL basic_empty: got %b expected 1", bus.empty);
      end
   endtask

   task automatic test_full;
      for (int i = 0; i < 16; i++) begin
         op(OP_WR, word_t'(i));
         vectors++;
         if (bus.almost_full !== (i + 1 >= 12) || bus.full !== (i + 1 == 16) || bus.count !== 5'(i + 1)) begin
            miscompares++;
            $display("FAIL full_fill%0d: got af %b full %b count %0d expected af %b full %b count %0d",
                     i, bus.almost_full, bus.full, bus.count, (i + 1 >= 12), (i + 1 == 16), i + 1);
         end
      end
      op(OP_WR, 8'hAA);
      vectors++;
      if (bus.overflow !== 1'b1 || bus.count !== 5'd16) begin
         miscompares++;
         $display("FAIL full_overflow: got ovf %b count %0d expected ovf 1 count 16", bus.overflow, bus.count);
      end
      for (int i = 0; i < 16; i++) begin
         op(OP_RD, 8'h00);
         vectors++;
         if (bus.D_out !== word_t'(i)) begin
            miscompares++; $display("FAIL full_drain%0d: got %h expected %h", i, bus.D_out, word_t'(i));
         end
      end
      vectors++;
      if (bus.empty !== 1'b1 || bus.count !== 5'd0) begin
         miscompares++; $display("FAIL full_drained: got empty %b count %0d expected 1 0", bus.empty, bus.count);
      end
   endtask

   task automatic test_underflow;
      op(OP_RD, 8'h00);
      vectors++;
      if (bus.underflow !== 1'b1 || bus.D_out !== 8'h0F || bus.count !== 5'd0) begin
         miscompares++;
         $display("FAIL underflow_set: got unf %b data %h count %0d expected 1 0f 0", bus.underflow, bus.D_out, bus.count);
      end
      // Error in the same cycle as err_clr: set must win for underflow, overflow clears.
      bus.err_clr = 1'b1;
      op(OP_RD, 8'h00);
      bus.err_clr = 1'b0;
      vectors++;
      if ({bus.overflow, bus.underflow} !== 2'b01) begin
         miscompares++; $display("FAIL err_set_wins: got %b expected 01", {bus.overflow, bus.underflow});
      end
      bus.err_clr = 1'b1;
      idle(1);
      bus.err_clr = 1'b0;
      vectors++;
      if ({bus.overflow, bus.underflow} !== 2'b00) begin
         miscompares++; $display("FAIL err_clr: got %b expected 00", {bus.overflow, bus.underflow});
      end
   endtask

   task automatic test_wrap;
      word_t exp_v;
      for (int pass = 0; pass < 2; pass++) begin
         for (int i = 0; i < 10; i++) op(OP_WR, word_t'(8'h40 + pass * 10 + i));
         vectors++;
         if (bus.count !== 5'd10) begin
            miscompares++; $display("FAIL wrap_count%0d: got %0d expected 10", pass, bus.count);
         end
         for (int i = 0; i < 10; i++) begin
            op(OP_RD, 8'h00);
            exp_v = word_t'(8'h40 + pass * 10 + i);
            vectors++;
            if (bus.D_out !== exp_v) begin
               miscompares++; $display("FAIL wrap_read%0d_%0d: got %h expected %h", pass, i, bus.D_out, exp_v);
            end
         end
      end
      vectors++;
      if (bus.count !== 5'd0 || bus.empty !== 1'b1) begin
         miscompares++; $display("FAIL wrap_end: got count %0d empty %b expected 0 1", bus.count, bus.empty);
      end
   endtask

   task automatic test_async_reset;
      for (int i = 0; i < 5; i++) op(OP_WR, word_t'(8'h90 + i));
      op(OP_RD, 8'h00);
      op(OP_WR, 8'h95);
      vectors++;
      if (bus.count !== 5'd5 || bus.D_out !== 8'h90) begin
         miscompares++; $display("FAIL arst_pre: got count %0d data %h expected 5 90", bus.count, bus.D_out);
      end
      #2 rst = 1'b0;
      #1;
      vectors++;
      if (bus.count !== 5'd0 || bus.empty !== 1'b1 || bus.D_out !== 8'h00 || bus.almost_full !== 1'b0) begin
         miscompares++;
         $display("FAIL arst_immediate: got count %0d empty %b data %h af %b expected 0 1 00 0", bus.count, bus.empty, bus.D_out, bus.almost_full);
      end
      idle(1);
      rst = 1'b1;
      op(OP_RD, 8'h00);
      vectors++;
      if (bus.underflow !== 1'b1 || bus.count !== 5'd0 || bus.D_out !== 8'h00) begin
         miscompares++;
         $display("FAIL arst_then_read: got unf %b count %0d data %h expected 1 0 00", bus.underflow, bus.count, bus.D_out);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_full();
      test_underflow();
      test_wrap();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
